stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-NOUT stream demultiplexer: the steering counterpart to the team's 3-bit 2:1 select mux. It accepts one valid/ready input stream of DW-bit beats and forwards each beat to the output channel chosen by `in_sel`. Each output has a one-beat register slot, so every output is driven from a flop. Optionally, it locks the route for a whole packet. It sits between a single producer and NOUT independent consumers in the datapath.

## Interface
- `DW`, 3, data width per beat
- `NOUT`, 2, number of output channels (2..8); `SW = $clog2(NOUT)` derived, min 1
- `clk`  input  1  clock, all state updates on rising edge
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low
- `in_valid`  input  1  input beat present
- `in_ready`  output  1  input beat accepted this cycle when high with `in_valid`
- `in_data`  input  DW  input beat data
- `in_sel`  input  SW  destination channel index
- `in_last`  input  1  final beat of packet
- `out_valid`  output  NOUT  per-channel slot occupied
- `out_ready`  input  NOUT  per-channel consumer ready
- `out_data`  output  NOUT*DW  channel k occupies bits [k*DW +: DW]
- `out_last`  output  NOUT  per-channel last flag
- `err_cnt`  output  8  saturating count of dropped beats (out-of-range select)

## Operation
- Route index `r`:
  - `in_sel`, or the locked index (see Configuration).
- Slot k "free":
  - `!out_valid[k] || out_ready[k]`.
- `in_ready`:
  - 1 if `r` ≥ NOUT (drop path).
  - Otherwise equals slot `r` free.
  - Combinational; 0 while `rst_n` low.
- Accept (`in_valid && in_ready`, `r` < NOUT):
  - Next edge: slot `r` loads `in_data`/`in_last`; `out_valid[r]`=1.
- Drain (`out_valid[k] && out_ready[k]`) with no load:
  - Next edge: `out_valid[k]`=0.
  - Data/last hold their last value.
- Simultaneous drain and load on the same slot:
  - Slot reloads; `out_valid` stays 1; full throughput with no bubble.
- Other slots are unaffected by accepts to slot `r`. Each channel drains independently.
- Drop (`r` ≥ NOUT, only possible when NOUT is not a power of 2):
  - Beat is consumed; no output changes.
  - `err_cnt` increments, saturating at 255.
- `in_valid` low: no state change except drains.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `err_cnt`=0, lock state IDLE.
- Reset mid-packet or mid-transfer:
  - All slot contents are discarded; lock is released.
  - Sources must restart the packet.

## Timing
- Latency: accepted beat visible on `out_*[r]` one cycle after acceptance.
- Throughput: one beat/cycle when the target consumer holds `out_ready` high.
- Output channels:
  - `out_valid`/`out_data`/`out_last` are registered.
  - Once `out_valid[k]` is 1, data/last are stable until the drain handshake.
- `in_ready` path: combinational from `out_valid`, `out_ready`, `in_sel`, and lock state. No combinational path from `in_data`.
- Producer rules: must hold `in_data`/`in_sel`/`in_last` stable while `in_valid`=1 and `in_ready`=0. Checked by bench assertion.

## Configuration
- Macro: `STREAM_DEMUX_PKT_LOCK_EN`.
- Defined: two-state FSM.
  - IDLE: route `r` = `in_sel`. An accepted beat with `in_last`=0 latches `in_sel` into `lock_sel` and moves to LOCKED.
  - LOCKED: route `r` = `lock_sel`; `in_sel` is ignored. An accepted beat with `in_last`=1 returns to IDLE.
  - Single-beat packet (`in_last`=1 in IDLE) stays in IDLE.
  - Out-of-range lock drops the whole packet; `err_cnt` increments once per beat.
- Undefined:
  - No FSM; `r` = `in_sel` every beat.
  - `in_last` is carried to `out_last` only.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-stream with `out_valid`=2'b11.
  - Required: `out_valid`=0, `out_data`=0, `err_cnt`=0, and `in_ready`=0 within the same cycle (async). After release, `in_ready`=1.
- Basic steering (NOUT=2):
  - Stimulus: beats 3'h5 sel=0, 3'h3 sel=1, both `out_ready`=1.
  - Required: `out_data[2:0]`=5 at cycle+1; `out_data[5:3]`=3 at cycle+2. One beat/cycle.
- Backpressure:
  - Stimulus: `out_ready[0]`=0; send 3'h1 then 3'h2 to sel=0.
  - Required: second beat sees `in_ready`=0 and slot 0 holds 1. Raising `out_ready[0]` drains 1 and loads 2 in the same cycle, with `out_valid[0]` staying 1.
- Independence:
  - Stimulus: slot 0 stalled full; send 3'h7 sel=1.
  - Required: accepted immediately; `out_data[5:3]`=7 next cycle.
- Drop (NOUT=3):
  - Stimulus: 300 beats with sel=3.
  - Required: `in_ready`=1 throughout; no `out_valid` asserted; `err_cnt` saturates at 255.
- Packet lock (macro defined):
  - Stimulus: 3-beat packet, sel=1 on beat 0 and sel=0 on beats 1–2, `in_last` on beat 2.
  - Required: all three beats appear on channel 1. The next packet with sel=0 goes to channel 0.
  - Without the macro: beats 1–2 go to channel 0.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NOUT valid/ready demultiplexer with one beat slot per channel.
// Define STREAM_DEMUX_PKT_LOCK_EN to hold the route for a whole packet.
module stream_demux #(
    parameter int DW   = 3,
    parameter int NOUT = 2,
    localparam int SW  = (NOUT > 2) ? $clog2(NOUT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic [SW-1:0]      in_sel,
    input  logic               in_last,
    output logic [NOUT-1:0]    out_valid,
    input  logic [NOUT-1:0]    out_ready,
    output logic [NOUT*DW-1:0] out_data,
    output logic [NOUT-1:0]    out_last,
    output logic [7:0]         err_cnt
);

    logic [SW-1:0]   route;
    logic [NOUT-1:0] hit;
    logic [NOUT-1:0] slot_free;
    logic            drop;
    logic            accept;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] lock_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !in_last)
                lock_sel <= in_sel;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (accept && !in_last) state_nxt = LOCKED;
            LOCKED: if (accept && in_last)  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        route = in_sel;
        if (state == LOCKED)
            route = lock_sel;
    end
`else
    assign route = in_sel;
`endif

    // Non-power-of-2 NOUT leaves select codes with no channel; those beats are dropped.
    assign drop      = 32'(route) >= NOUT;
    assign slot_free = ~out_valid | out_ready;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NOUT; k++)
            hit[k] = (32'(route) == k);
    end

    assign in_ready = rst_n && (drop || (|(hit & slot_free)));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            out_last  <= '0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (accept && hit[k]) begin
                    out_valid[k]         <= 1'b1;
                    out_data[k*DW +: DW] <= in_data;
                    out_last[k]          <= in_last;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (accept && drop && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: randomized and directed scoreboard bench for stream_demux (NOUT=3).
// Expected beats are queued per channel at acceptance; a monitor pops them on drain.
`timescale 1ns/1ps
module tb_stream_demux;

    localparam int DW   = 3;
    localparam int NOUT = 3;
    localparam int SW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     in_sel;
    logic              in_last;
    logic [NOUT-1:0]   out_valid;
    logic [NOUT-1:0]   out_ready;
    logic [NOUT*DW-1:0] out_data;
    logic [NOUT-1:0]   out_last;
    logic [7:0]        err_cnt;

    stream_demux #(.DW(DW), .NOUT(NOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            cyc;
    } beat_t;

    beat_t expq [NOUT][$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    popped [NOUT];
    bit    occ [NOUT];
    int    err_m = 0;
    bit    in_pkt = 0;
    int    pkt_dest = 0;

    bit            pv;
    logic [DW-1:0] pd;
    int            ps;
    bit            pl;
    logic [NOUT-1:0] rdy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    property p_hold;
        @(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=>
        (!in_valid || ($stable(in_data) && $stable(in_sel) && $stable(in_last)));
    endproperty
    a_hold: assert property (p_hold)
        else begin
            miscompares++;
            $display("FAIL producer_hold at cycle %0d", cyc);
        end

    // One cycle: drive at negedge, compare handshake and err_cnt, advance the model.
    task automatic run_cycle();
        int r;
        bit drop;
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        in_valid  = pv;
        in_data   = pd;
        in_sel    = SW'(ps);
        in_last   = pl;
        out_ready = rdy;
        #1;
        r       = in_pkt ? pkt_dest : ps;
        drop    = (r >= NOUT);
        exp_rdy = drop || !occ[r] || rdy[r];
        chk("in_ready", in_ready, int'(exp_rdy));
        chk("err_cnt", err_cnt, err_m);
        acc = pv && exp_rdy;
        for (int k = 0; k < NOUT; k++)
            if (rdy[k] && !(acc && !drop && r == k)) occ[k] = 1'b0;
        if (acc) begin
            if (drop) begin
                if (err_m < 255) err_m++;
            end else begin
                beat_t b;
                b.d = pd;
                b.l = pl;
                b.cyc = cyc;
                expq[r].push_back(b);
                occ[r] = 1'b1;
            end
`ifdef STREAM_DEMUX_PKT_LOCK_EN
            if (!pl) begin
                in_pkt   = 1'b1;
                pkt_dest = r;
            end else begin
                in_pkt = 1'b0;
            end
`endif
            pv = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input int s, input bit l, output int n);
        pv = 1'b1;
        pd = d;
        ps = s;
        pl = l;
        n  = 0;
        while (pv && n < 64) begin
            run_cycle();
            n++;
        end
        if (pv) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no accept expected accept (cycle %0d)", cyc);
            pv = 1'b0;
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < NOUT; k++) begin
            expq[k].delete();
            occ[k] = 1'b0;
        end
        err_m  = 0;
        in_pkt = 1'b0;
        pv     = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        flush_model();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every occupied slot must show the oldest queued beat for its channel.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            for (int k = 0; k < NOUT; k++) begin
                if (out_valid[k]) begin
                    if (expq[k].size() == 0) begin
                        chk($sformatf("spurious_valid_ch%0d", k), 1, 0);
                    end else begin
                        chk($sformatf("data_ch%0d", k), out_data[k*DW +: DW], expq[k][0].d);
                        chk($sformatf("last_ch%0d", k), out_last[k], expq[k][0].l);
                        if (out_ready[k]) begin
                            void'(expq[k].pop_front());
                            popped[k]++;
                        end
                    end
                end else if (expq[k].size() > 0 && expq[k][0].cyc < cyc) begin
                    chk($sformatf("missing_valid_ch%0d", k), 0, 1);
                end
            end
        end
    end

    initial begin
        int n;
        int b0;
        int b1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sel = '0;
        in_last = 1'b0;
        out_ready = '0;
        pv = 1'b0;
        pd = '0;
        ps = 0;
        pl = 1'b1;
        rdy = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_err_cnt", err_cnt, 0);
        chk("init_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        rdy = '1;
        send(3'h5, 0, 1'b1, n);
        chk("steer0_cycles", n, 1);
        send(3'h3, 1, 1'b1, n);
        chk("steer1_cycles", n, 1);
        run_cycle();
        chk("steer_ch1_data", out_data[5:3], 3);

        rdy = 3'b110;
        send(3'h1, 0, 1'b1, n);
        chk("bp_first_cycles", n, 1);
        send(3'h7, 1, 1'b1, n);
        chk("indep_cycles", n, 1);
        pv = 1'b1; pd = 3'h2; ps = 0; pl = 1'b1;
        run_cycle();
        run_cycle();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", out_data[2:0], 1);
        rdy = 3'b111;
        run_cycle();
        chk("bp_valid_before", out_valid[0], 1);
        run_cycle();
        chk("bp_reload_valid", out_valid[0], 1);
        chk("bp_reload_data", out_data[2:0], 2);

        rdy = '0;
        send(3'h5, 0, 1'b1, n);
        send(3'h6, 1, 1'b1, n);
        run_cycle();
        chk("pre_rst_valid", out_valid[1:0], 3);
        mid_reset();
        run_cycle();
        chk("post_rst_in_ready", in_ready, 1);

        rdy = '1;
        for (int i = 0; i < 300; i++) send(DW'(i), 3, 1'b1, n);
        run_cycle();
        chk("err_sat", err_cnt, 255);

        b0 = popped[0];
        b1 = popped[1];
        send(3'h4, 1, 1'b0, n);
        send(3'h5, 0, 1'b0, n);
        send(3'h6, 0, 1'b1, n);
        send(3'h2, 0, 1'b1, n);
        repeat (3) run_cycle();
`ifdef STREAM_DEMUX_PKT_LOCK_EN
        chk("lock_ch1_beats", popped[1] - b1, 3);
        chk("lock_ch0_beats", popped[0] - b0, 1);
`else
        chk("nolock_ch1_beats", popped[1] - b1, 1);
        chk("nolock_ch0_beats", popped[0] - b0, 3);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
                pv = 1'b1;
                pd = DW'($urandom);
                ps = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                pl = ($urandom_range(0, 3) == 0);
            end
            rdy = NOUT'($urandom);
            run_cycle();
            if (i == 1500) mid_reset();
        end

        pv = 1'b0;
        rdy = '1;
        repeat (4) run_cycle();
        for (int k = 0; k < NOUT; k++)
            chk($sformatf("drain_empty_ch%0d", k), expq[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
